frame_loader: RTL and testbench
===============================

Name: frame_loader

Overview:
- Upstream stage for the 4x4 convolution block.
- Accepts a serial stream of 5-bit pixels over a valid/ready handshake and assembles them row-major into 4x4 frames.
- Presents each complete frame as one flattened word with a frame valid/ready handshake.
- Ping-pong buffered: the next frame can fill while the consumer still holds the current one.

Parameters:
- PIX_W, 5, pixel width in bits.
- ROWS, 4, frame rows.
- COLS, 4, frame columns; NPIX = ROWS*COLS = 16.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- pix_in  in  PIX_W  pixel data.
- pix_sof  in  1  start-of-frame marker, qualified by the pixel handshake.
- pix_valid  in  1  pixel offered.
- pix_ready  out  1  pixel can be accepted.
- frame_data  out  NPIX*PIX_W  frame; pixel i at bits [i*PIX_W +: PIX_W]; i = row*COLS+col.
- frame_valid  out  1  frame_data holds a complete frame.
- frame_ready  in  1  consumer takes the frame.
- frame_abort  out  1  one-cycle pulse: a partial frame was discarded.
- frame_count  out  CNT_W  number of frames handed off; wraps.

Behaviour:
- Storage: two banks (bank0, bank1), each NPIX x PIX_W.
  - Each bank has a registered full flag.
  - wr_ptr selects the bank being filled; rd_ptr selects the bank presented.
  - pix_idx (0..NPIX-1) is the write position.
- Reset (async, rst=1) forces:
  - full flags 0; wr_ptr=0; rd_ptr=0; pix_idx=0.
  - frame_valid=0; frame_abort=0; frame_count=0.
  - pix_ready=0 while rst=1.
  - Bank contents are not cleared; frame_data is don't-care while frame_valid=0.
- pix_ready = !rst && !full[wr_ptr]. It is combinational from registered state only and never depends on frame_ready in the same cycle.
- Pixel accepted on a rising edge when pix_valid && pix_ready.
  - It is written to bank[wr_ptr][pix_idx], then pix_idx increments.
  - If pix_sof=1 on an accepted pixel, it is written at index 0 and pix_idx becomes 1.
  - If the discarded pix_idx was not 0, frame_abort pulses high for the following cycle.
  - pix_sof on a non-accepted cycle is ignored.
- Frame completion: the accepted pixel at pix_idx=NPIX-1 (or sof with NPIX=1, not supported) does the following on the same edge:
  - sets full[wr_ptr];
  - toggles wr_ptr;
  - wraps pix_idx to 0.
- Latency: 16th pixel accepted at edge N → frame_valid=1 in the cycle after edge N (1 cycle).
- frame_valid = full[rd_ptr]; frame_data = bank[rd_ptr], unmuxed otherwise.
  - frame_data and frame_valid stay stable while frame_valid && !frame_ready.
- Hand-off on an edge with frame_valid && frame_ready:
  - clears full[rd_ptr];
  - toggles rd_ptr;
  - frame_count increments (2^CNT_W-1 → 0).
- Both banks full: pix_ready=0 and the stream stalls. A hand-off frees a bank, and pix_ready=1 the next cycle.
- Simultaneous events on one edge:
  - Frame completion and hand-off on different banks: both take effect. The set and clear target different flags, so both happen.
  - Back-to-back frames with a consumer holding frame_ready=1 sustain 1 pixel/cycle with no bubbles.
- Reset mid-frame or with frames pending: all state is discarded immediately and no frame_abort is generated.
- frame_valid must never rise for a partial frame.

Decomposition:
- Shared package: PIX_W, ROWS, COLS, NPIX, and a frame-index helper (row*COLS+col). The convolution stage uses the same constants for its window indexing.
- Natural sub-module: frame_bank (one NPIX-deep register bank with write-enable, write index, flattened read port), instantiated twice.
- The control FSM (idle/filling per bank, encoded as full flags + pix_idx) stays in frame_loader.

Test Plan:
- Stream pixels 1..16, sof on the first, consumer frame_ready=1 → frame_valid one cycle after the 16th acceptance.
  - frame_data[4:0]=1, [79:75]=16.
  - frame_count=1.
  - frame_abort never pulses.
- frame_ready=0, stream 32 pixels (1..16, then 17..31 wrapping mod 32, then 0).
  - Both banks fill; pix_ready drops after pixel 32 and pixel 33 is stalled.
  - Raise frame_ready for one cycle: frame 1 handed off, frame 2 (17..0) presented next cycle, and pix_ready=1 the same cycle.
- Send 7 pixels, then an accepted pixel with sof=1 and value 9, then 15 more pixels (10..24 mod 32).
  - frame_abort pulses once.
  - The resulting frame has pixel0=9.
- Continuous 1 pixel/cycle for 4 frames with frame_ready=1 → pix_ready never drops; frame_count=4; each frame_data matches its stream.
- Assert rst mid-frame (after 10 pixels) and while a full frame is pending.
  - All outputs go to reset values immediately and asynchronously.
  - After release, a fresh 16-pixel frame completes normally.
- Hold frame_ready=0 for 20 cycles with a frame presented and pix_valid toggling randomly → frame_data/frame_valid constant throughout.

Source files
------------

// File: rtl/frame_loader_pkg.sv
// Shared frame geometry for the frame loader and the 4x4 convolution stage.
// Also holds the per-bank fill state and a row/col to linear pixel index helper.
package frame_loader_pkg;

  localparam int unsigned PIX_W   = 5;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned NPIX    = ROWS * COLS;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = $clog2(NPIX);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned FRAME_W = NPIX * PIX_W;

  // A bank is either accepting pixels or holding a complete frame for the consumer.
  typedef enum logic {
    BANK_FILLING = 1'b0,
    BANK_FULL    = 1'b1
  } bank_state_e;

  // Row-major linear pixel index; also used for window indexing downstream.
  function automatic logic [IDX_W-1:0] frame_index(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return IDX_W'(IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col));
  endfunction

endpackage

// File: rtl/frame_loader_bank.sv
// One NPIX-deep pixel register bank: single indexed write port, flattened read port.
// Contents are intentionally not reset; validity is tracked by the owner's full flag.
module frame_bank
  import frame_loader_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [PIX_W-1:0]   wdata,
  output logic [FRAME_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [NPIX];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Pixel i lands at bits [i*PIX_W +: PIX_W].
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(NPIX); i++) begin
      rdata[i*PIX_W +: PIX_W] = mem[i];
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Ping-pong frame assembler: serial pixels in, one flattened 4x4 frame per hand-off out.
// Bank control is a per-bank fill state plus a shared write position.
module frame_loader
  import frame_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_sof,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               frame_abort,
  output logic [CNT_W-1:0]   frame_count
);

  bank_state_e        full_q [2];
  bank_state_e        full_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept_c;
  logic               handoff_c;
  logic [IDX_W-1:0]   wr_idx_c;
  logic [FRAME_W-1:0] rdata0, rdata1;
  logic               we0_c, we1_c;

  // Ready depends on registered state only, never on frame_ready.
  assign pix_ready   = !rst && (full_q[wr_ptr_q] == BANK_FILLING);
  assign frame_valid = (full_q[rd_ptr_q] == BANK_FULL);
  assign frame_data  = rd_ptr_q ? rdata1 : rdata0;
  assign frame_abort = abort_q;
  assign frame_count = count_q;

  assign accept_c  = pix_valid && pix_ready;
  assign handoff_c = frame_valid && frame_ready;
  assign wr_idx_c  = pix_sof ? '0 : pix_idx_q;
  assign we0_c     = accept_c && !wr_ptr_q;
  assign we1_c     = accept_c &&  wr_ptr_q;

  frame_bank u_bank0 (
    .clk   (clk),
    .we    (we0_c),
    .widx  (wr_idx_c),
    .wdata (pix_in),
    .rdata (rdata0)
  );

  frame_bank u_bank1 (
    .clk   (clk),
    .we    (we1_c),
    .widx  (wr_idx_c),
    .wdata (pix_in),
    .rdata (rdata1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q[0] <= BANK_FILLING;
      full_q[1] <= BANK_FILLING;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      pix_idx_q <= '0;
      abort_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      full_q[0] <= full_d[0];
      full_q[1] <= full_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pix_idx_q <= pix_idx_d;
      abort_q   <= abort_d;
      count_q   <= count_d;
    end
  end

  // Completion and hand-off can share an edge: completion needs a filling bank and
  // hand-off needs a full one, so they always touch different flags.
  always_comb begin
    full_d[0] = full_q[0];
    full_d[1] = full_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pix_idx_d = pix_idx_q;
    abort_d   = 1'b0;
    count_d   = count_q;

    if (accept_c) begin
      abort_d = pix_sof && (pix_idx_q != '0);
      if (wr_idx_c == IDX_W'(NPIX - 1)) begin
        full_d[wr_ptr_q] = BANK_FULL;
        wr_ptr_d         = !wr_ptr_q;
        pix_idx_d        = '0;
      end else begin
        pix_idx_d = wr_idx_c + IDX_W'(1);
      end
    end

    if (handoff_c) begin
      full_d[rd_ptr_q] = BANK_FILLING;
      rd_ptr_d         = !rd_ptr_q;
      count_d          = count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader against a queue-based model of pending frames.
module tb_frame_loader;
  import frame_loader_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [PIX_W-1:0]   pix_in;
  logic               pix_sof;
  logic               pix_valid;
  logic               pix_ready;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;
  logic               frame_abort;
  logic [CNT_W-1:0]   frame_count;

  frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_sof     (pix_sof),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_abort (frame_abort),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: complete frames waiting for the consumer (at most two), plus the partial one.
  logic [FRAME_W-1:0] pend[$];
  logic [FRAME_W-1:0] part;
  int                 part_len;
  bit                 abort_exp;
  logic [CNT_W-1:0]   cnt_exp;

  task automatic chk(input string tag, input logic [FRAME_W-1:0] got,
                     input logic [FRAME_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    part      = '0;
    part_len  = 0;
    abort_exp = 1'b0;
    cnt_exp   = '0;
  endtask

  // One clock cycle: check outputs mid-cycle, drive inputs, advance the model.
  task automatic step(input bit v, input bit s, input logic [PIX_W-1:0] d, input bit fr);
    bit acc;
    bit ho;
    @(negedge clk);
    chk("pix_ready",   FRAME_W'(pix_ready),   FRAME_W'(pend.size() < 2));
    chk("frame_valid", FRAME_W'(frame_valid), FRAME_W'(pend.size() > 0));
    if (pend.size() > 0) chk("frame_data", frame_data, pend[0]);
    chk("frame_abort", FRAME_W'(frame_abort), FRAME_W'(abort_exp));
    chk("frame_count", FRAME_W'(frame_count), FRAME_W'(cnt_exp));
    pix_valid   = v;
    pix_sof     = s;
    pix_in      = d;
    frame_ready = fr;
    acc = v && (pend.size() < 2);
    ho  = fr && (pend.size() > 0);
    abort_exp = 1'b0;
    if (ho) begin
      void'(pend.pop_front());
      cnt_exp = cnt_exp + CNT_W'(1);
    end
    if (acc) begin
      if (s) begin
        abort_exp = (part_len != 0);
        part_len  = 0;
      end
      part[part_len*PIX_W +: PIX_W] = d;
      part_len++;
      if (part_len == int'(NPIX)) begin
        pend.push_back(part);
        part_len = 0;
      end
    end
  endtask

  task automatic idle(input int n, input bit fr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, fr);
  endtask

  task automatic send_frame(input bit fr, input int base);
    for (int i = 0; i < int'(NPIX); i++) step(1'b1, i == 0, PIX_W'(base + i), fr);
  endtask

  // Reset raised asynchronously between edges; outputs must clear before any clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    pix_valid = 1'b0;
    #1;
    chk("rst_pix_ready",   FRAME_W'(pix_ready),   '0);
    chk("rst_frame_valid", FRAME_W'(frame_valid), '0);
    chk("rst_frame_abort", FRAME_W'(frame_abort), '0);
    chk("rst_frame_count", FRAME_W'(frame_count), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    pix_in      = '0;
    pix_sof     = 1'b0;
    pix_valid   = 1'b0;
    frame_ready = 1'b0;
    model_reset();
    #1;
    chk("init_pix_ready",   FRAME_W'(pix_ready),   '0);
    chk("init_frame_valid", FRAME_W'(frame_valid), '0);
    chk("init_frame_abort", FRAME_W'(frame_abort), '0);
    chk("init_frame_count", FRAME_W'(frame_count), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single frame 1..16 to an always-ready consumer.
    send_frame(1'b1, 1);
    idle(3, 1'b1);

    // Consumer stalled: both banks fill, 33rd pixel waits for a hand-off.
    for (int i = 1; i <= 32; i++) step(1'b1, i == 1, PIX_W'(i), 1'b0);
    repeat (3) step(1'b1, 1'b0, PIX_W'(1), 1'b0);
    step(1'b1, 1'b0, PIX_W'(1), 1'b1);
    step(1'b1, 1'b0, PIX_W'(1), 1'b0);
    idle(4, 1'b1);

    // Restart mid-frame: 7 pixels, sof with 9, then 10..24.
    for (int i = 1; i <= 7; i++) step(1'b1, i == 1, PIX_W'(i), 1'b1);
    step(1'b1, 1'b1, PIX_W'(9), 1'b1);
    for (int i = 10; i <= 24; i++) step(1'b1, 1'b0, PIX_W'(i), 1'b1);
    idle(3, 1'b1);

    // Four back-to-back frames at one pixel per cycle.
    for (int f = 0; f < 4; f++) send_frame(1'b1, int'($urandom_range(0, 31)));
    idle(3, 1'b1);

    // Reset mid-frame, then with a frame pending, then a clean frame.
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, PIX_W'(i + 3), 1'b0);
    async_reset();
    send_frame(1'b0, 5);
    idle(2, 1'b0);
    async_reset();
    send_frame(1'b1, 11);
    idle(3, 1'b1);

    // Frame held for 20 cycles while pixels trickle in.
    send_frame(1'b0, 20);
    for (int i = 0; i < 20; i++)
      step(1'(($urandom) & 1), 1'b0, PIX_W'($urandom), 1'b0);
    idle(4, 1'b1);

    // Unconstrained random traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           PIX_W'($urandom), $urandom_range(0, 2) != 0);
    idle(4, 1'b1);

    // Enough hand-offs to wrap the frame counter.
    for (int f = 0; f < 260; f++) send_frame(1'b1, int'($urandom_range(0, 31)));
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
